q_sys_msgdma_0_rl_tx_adapter: RTL and testbench

//  Avalon-ST timing adapter, opposite direction to the mSGDMA ready-latency sink adapter.
//  - Upstream: source with readyLatency 0.
//  - Downstream: sink with readyLatency = READY_LATENCY.
//  - Incoming beats are buffered in a small FIFO.
//  - Beats launch only inside the downstream ready window.
//  - Registered out_valid/out_data give timing isolation on the mSGDMA streaming path.

---
 rtl/q_sys_msgdma_0_rl_tx_adapter.sv | 112 +++++++++++
 tb/tb_q_sys_msgdma_0_rl_tx_adapter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/q_sys_msgdma_0_rl_tx_adapter.sv
// Avalon-ST timing adapter: readyLatency-0 source to a READY_LATENCY sink, via a small FIFO.
// Optional statistics counters are enabled by defining Q_SYS_MSGDMA_0_RL_TX_STATS_EN.
module q_sys_msgdma_0_rl_tx_adapter #(
    parameter int DATA_W        = 64,
    parameter int READY_LATENCY = 2,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          in_ready,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
`ifdef Q_SYS_MSGDMA_0_RL_TX_STATS_EN
    ,
    input  logic                          stats_clear,
    output logic [31:0]                   beat_count,
    output logic [31:0]                   stall_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              win;

    // Full blocks input even if a pop happens this cycle: in_ready depends on the register only.
    assign in_ready   = !reset && (count < CW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = win && (count != '0);
    assign fill_level = count;

    // Ready window: out_ready delayed so a launch lands exactly READY_LATENCY cycles after it.
    generate
        if (READY_LATENCY == 1) begin : g_rl1
            assign win = out_ready;
        end else begin : g_rln
            logic [READY_LATENCY-2:0] rdy_pipe;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdy_pipe <= '0;
                end else begin
                    rdy_pipe[0] <= out_ready;
                    for (int i = 1; i < READY_LATENCY - 1; i++) begin
                        rdy_pipe[i] <= rdy_pipe[i-1];
                    end
                end
            end

            assign win = rdy_pipe[READY_LATENCY-2];
        end
    endgenerate

    // Storage needs no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                out_data <= mem[rd_ptr];
            end
            out_valid <= pop;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef Q_SYS_MSGDMA_0_RL_TX_STATS_EN
    // Saturating counters; a clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            if (out_valid && (beat_count != '1)) begin
                beat_count <= beat_count + 32'd1;
            end
            if (in_valid && !in_ready && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_q_sys_msgdma_0_rl_tx_adapter.sv
// Bench for q_sys_msgdma_0_rl_tx_adapter: table vectors, corner sequences and random traffic
// checked against a queue-based model of the ready-window rules.
module tb_q_sys_msgdma_0_rl_tx_adapter;

    localparam int DW    = 64;
    localparam int RL    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_ready;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    fill_level;
    logic          stats_clear;
`ifdef Q_SYS_MSGDMA_0_RL_TX_STATS_EN
    logic [31:0]   beat_count;
    logic [31:0]   stall_count;
`endif

    q_sys_msgdma_0_rl_tx_adapter #(
        .DATA_W(DW), .READY_LATENCY(RL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_ready   (in_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fill_level (fill_level)
`ifdef Q_SYS_MSGDMA_0_RL_TX_STATS_EN
        ,
        .stats_clear(stats_clear),
        .beat_count (beat_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of held beats plus history of past out_ready values.
    logic [DW-1:0] mq[$];
    logic          m_ov   = 1'b0;
    logic [DW-1:0] m_od   = '0;
    logic [3:0]    m_hist = '0;
    logic [31:0]   m_beat = '0;
    logic [31:0]   m_stall = '0;

    logic          last_ir;
    int            ov_seen;
    logic [DW-1:0] recv[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic rst, input logic sclr);
        logic [4:0] h;
        logic       win, exp_ir, launch, acc;
        in_valid = iv; in_data = d; out_ready = ordy; reset = rst; stats_clear = sclr;
        #1;
        exp_ir  = !rst && (mq.size() < DEPTH);
        last_ir = in_ready;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
        h   = {m_hist, ordy};
        win = h[RL-1];
        if (rst || sclr) begin
            m_beat = '0; m_stall = '0;
        end else begin
            if (m_ov && m_beat != '1) m_beat = m_beat + 1;
            if (iv && !exp_ir && m_stall != '1) m_stall = m_stall + 1;
        end
        if (rst) begin
            mq.delete(); m_ov = 1'b0; m_od = '0; m_hist = '0;
        end else begin
            launch = win && (mq.size() > 0);
            acc    = iv && exp_ir;
            if (launch) m_od = mq.pop_front();
            m_ov = launch;
            if (acc) mq.push_back(d);
            m_hist = {m_hist[2:0], ordy};
        end
        @(posedge clk); #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        chk("out_data", out_data, m_od);
        chk("fill_level", {60'd0, fill_level}, 64'(mq.size()));
`ifdef Q_SYS_MSGDMA_0_RL_TX_STATS_EN
        chk("beat_count", {32'd0, beat_count}, {32'd0, m_beat});
        chk("stall_count", {32'd0, stall_count}, {32'd0, m_stall});
`endif
        if (out_valid) begin
            ov_seen++;
            recv.push_back(out_data);
        end
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          rst;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [3:0]    e_fill;
    } vec_t;

    vec_t vt[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] sent[$];

        // out_ready held high: three pushes emerge two cycles later, in order.
        vt[0] = '{1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 1'b0, 64'h00, 4'd0};
        vt[1] = '{1'b1, 64'h11, 1'b1, 1'b0, 1'b1, 1'b0, 64'h00, 4'd1};
        vt[2] = '{1'b1, 64'h22, 1'b1, 1'b0, 1'b1, 1'b1, 64'h11, 4'd1};
        vt[3] = '{1'b1, 64'h33, 1'b1, 1'b0, 1'b1, 1'b1, 64'h22, 4'd1};
        vt[4] = '{1'b0, 64'h00, 1'b1, 1'b0, 1'b1, 1'b1, 64'h33, 4'd0};
        vt[5] = '{1'b0, 64'h00, 1'b1, 1'b0, 1'b1, 1'b0, 64'h33, 4'd0};
        for (int i = 0; i < 6; i++) begin
            step(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].rst, 1'b0);
            chk("tbl_in_ready", {63'd0, last_ir}, {63'd0, vt[i].e_ir});
            chk("tbl_out_valid", {63'd0, out_valid}, {63'd0, vt[i].e_ov});
            chk("tbl_out_data", out_data, vt[i].e_od);
            chk("tbl_fill", {60'd0, fill_level}, {60'd0, vt[i].e_fill});
        end

        // Single-cycle out_ready pulse releases exactly one of four queued beats.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 64'hA0 + 64'(i), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        ov_seen = 0;
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pulse_ov_t2", {63'd0, out_valid}, 64'd1);
        chk("pulse_data", out_data, 64'hA0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("pulse_count", 64'(ov_seen), 64'd1);
        chk("pulse_fill", {60'd0, fill_level}, 64'd3);

        // Fill to the top with out_ready low, then drain in order.
        step(0, 0, 0, 1, 0);
        sent.delete();
        for (int i = 0; i < 10; i++) begin
            step(1, 64'hB0 + 64'(i), 0, 0, 0);
            if (i < 8) sent.push_back(64'hB0 + 64'(i));
        end
        chk("full_fill", {60'd0, fill_level}, 64'd8);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        recv.delete();
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
        chk("drain_count", 64'(recv.size()), 64'd8);
        for (int i = 0; i < 8 && i < recv.size(); i++) chk("drain_order", recv[i], sent[i]);

        // Full with a launch: no pass-through, in_ready returns the following cycle.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 64'hC0 + 64'(i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 64'hD0, 0, 0, 0);
        chk("full_pop_ir", {63'd0, last_ir}, 64'd0);
        chk("full_pop_fill", {60'd0, fill_level}, 64'd7);
        step(1, 64'hD1, 0, 0, 0);
        chk("refill_ir", {63'd0, last_ir}, 64'd1);
        chk("refill_fill", {60'd0, fill_level}, 64'd8);

        // Reset mid-operation discards data and the in-flight window.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 64'hE0 + 64'(i), (i == 4), 0, 0);
        step(0, 0, 1, 1, 0);
        chk("rst_ov", {63'd0, out_valid}, 64'd0);
        chk("rst_fill", {60'd0, fill_level}, 64'd0);
        for (int i = 0; i < 3; i++) step(1, 64'hF0 + 64'(i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("post_rst_ov_t1", {63'd0, out_valid}, 64'd0);
        step(0, 0, 1, 0, 0);
        chk("post_rst_ov_t2", {63'd0, out_valid}, 64'd1);
        chk("post_rst_data", out_data, 64'hF0);

`ifdef Q_SYS_MSGDMA_0_RL_TX_STATS_EN
        // Six launched beats and three stalled offers, then a clear.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 64'h100 + 64'(i), 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 64'h200, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk("stats_beat", {32'd0, beat_count}, 64'd6);
        chk("stats_stall", {32'd0, stall_count}, 64'd3);
        step(0, 0, 0, 0, 1);
        chk("stats_clr_beat", {32'd0, beat_count}, 64'd0);
        chk("stats_clr_stall", {32'd0, stall_count}, 64'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
